pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameters SHALL be: MUL_CYCLES, default 3, EX stall cycles for a multiply (range 2..63); DIV_CYCLES, default 32, EX stall cycles for a divide (range 2..63).
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 stall_req_if  in  1  IF stage stall request.
REQ-005 stall_req_id  in  1  ID stage stall request (load-use hazard).
REQ-006 stall_req_mem  in  1  MEM stage stall request (memory wait).
REQ-007 md_start  in  1  EX issues a multi-cycle HI/LO operation this cycle.
REQ-008 md_is_div  in  1  qualifies md_start: 1 = divide, 0 = multiply.
REQ-009 exc_flush  in  1  exception/eret flush request from MEM.
REQ-010 exc_pc  in  32  redirect target that accompanies exc_flush.
REQ-011 stall  out  5  hold vector: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB.
REQ-012 flush  out  1  clear all pipeline registers and redirect the PC.
REQ-013 flush_pc  out  32  redirect target; valid only while flush=1.
REQ-014 md_busy  out  1  multi-cycle HI/LO unit sequencing is in progress.
REQ-015 md_done  out  1  one-cycle pulse: HI/LO result is final and may advance into EX/MEM.

Function
REQ-016 FSM states SHALL be IDLE and MD_BUSY, with a 6-bit down-counter cnt.
REQ-017 Internal EX request ex_req SHALL be 1 when (IDLE and md_start and not exc_flush), or when (MD_BUSY and cnt != 1), or when (MD_BUSY and cnt == 1 and stall_req_mem).
REQ-018 stall SHALL be driven from the highest-priority requester as follows: MEM gives 5'b01111; else EX gives 5'b00111; else ID gives 5'b00011; else IF gives 5'b00001; else 5'b00000.
REQ-019 stall SHALL be combinational from the current inputs and state, with zero cycles of latency.
REQ-020 When exc_flush=1, flush SHALL be 1, flush_pc SHALL equal exc_pc, and stall SHALL be 5'b00000, all in the same cycle and regardless of any request.
REQ-021 When exc_flush=0, flush SHALL be 0 and flush_pc SHALL be 0.
REQ-022 IDLE to MD_BUSY SHALL occur when md_start=1 and exc_flush=0, loading cnt with DIV_CYCLES if md_is_div=1, else MUL_CYCLES.
REQ-023 In MD_BUSY with cnt > 1, cnt SHALL decrement by 1 each cycle, independent of stall_req_mem.
REQ-024 In MD_BUSY with cnt == 1 and stall_req_mem=1, cnt SHALL hold at 1, md_done SHALL be 0, and the state SHALL remain MD_BUSY; completion is deferred until MEM releases.
REQ-025 In MD_BUSY with cnt == 1 and stall_req_mem=0, md_done SHALL be 1 for exactly that cycle and the next state SHALL be IDLE.
REQ-026 The total EX stall for an uncontended operation SHALL be exactly N cycles (the md_start cycle plus N-1 MD_BUSY cycles), where N is the loaded value; the md_done cycle SHALL not stall EX.
REQ-027 md_busy SHALL equal (state == MD_BUSY), and md_done SHALL only be asserted while md_busy=1.
REQ-028 md_start while in MD_BUSY SHALL be ignored: no reload and no effect on cnt.
REQ-029 exc_flush while in MD_BUSY SHALL abort the operation: next state IDLE, cnt cleared to 0, and no md_done, even if cnt == 1 in that cycle.
REQ-030 md_start together with exc_flush in IDLE SHALL be ignored: the state remains IDLE.
REQ-031 md_is_div SHALL be sampled only in the cycle where md_start is accepted.

Reset
REQ-032 While rst=1, stall SHALL be 5'b00000, flush SHALL be 0, flush_pc SHALL be 0, md_busy SHALL be 0 and md_done SHALL be 0, regardless of the other inputs.
REQ-033 On the first rising edge with rst=1, the state SHALL become IDLE and cnt SHALL become 0, including when rst occurs mid-operation in MD_BUSY.
REQ-034 After rst deasserts, the first md_start SHALL be accepted in that same cycle.

Verification
REQ-035 Priority: stall_req_if=1, stall_req_id=1, all else 0 -> stall=5'b00011; additionally set stall_req_mem=1 -> stall=5'b01111.
REQ-036 Multiply: md_start=1 with md_is_div=0 at cycle t -> stall=5'b00111 at cycles t..t+2, md_done=1 only at t+3 with stall=5'b00000 at t+3, md_busy=1 at t+1..t+3.
REQ-037 Divide with MEM contention: md_start=1 with md_is_div=1 at t, stall_req_mem=1 at t+31..t+33 -> stall=5'b01111 at t+31..t+33, md_done=1 only at t+34.
REQ-038 Flush abort: divide started at t, exc_flush=1 with exc_pc=32'hBFC00380 at t+10 -> flush=1, flush_pc=32'hBFC00380 and stall=5'b00000 at t+10; md_busy=0 from t+11; md_done never asserted.
REQ-039 Ignored starts: md_start=1 at t+1 during a multiply -> md_done only at t+3; md_start=1 together with exc_flush=1 in IDLE -> md_busy stays 0.
REQ-040 Reset mid-operation: divide started, rst=1 at t+5 -> all outputs 0 at t+5, IDLE from t+6; md_start=1 at t+6 -> stall=5'b00111 at t+6.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: prioritises stall requests, handles exception flushes,
// and sequences the multi-cycle HI/LO multiply/divide unit.
module pipeline_ctrl #(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_req_if,
  input  logic        stall_req_id,
  input  logic        stall_req_mem,
  input  logic        md_start,
  input  logic        md_is_div,
  input  logic        exc_flush,
  input  logic [31:0] exc_pc,
  output logic [4:0]  stall,
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic        md_busy,
  output logic        md_done
);

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam logic [4:0] STALL_NONE = 5'b00000;
  localparam logic [4:0] STALL_IF   = 5'b00001;
  localparam logic [4:0] STALL_ID   = 5'b00011;
  localparam logic [4:0] STALL_EX   = 5'b00111;
  localparam logic [4:0] STALL_MEM  = 5'b01111;

  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES);

  md_state_t  state;
  md_state_t  state_next;
  logic [5:0] cnt;
  logic [5:0] cnt_next;

  logic start_ok;
  logic last_cycle;
  logic ex_req;

  assign start_ok   = (state == IDLE) && md_start && !exc_flush;
  assign last_cycle = (state == MD_BUSY) && (cnt == 6'd1);

  // EX keeps requesting a stall until the final count can retire past a quiet MEM stage.
  assign ex_req = start_ok
               || ((state == MD_BUSY) && (cnt != 6'd1))
               || (last_cycle && stall_req_mem);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 6'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (start_ok) begin
          state_next = MD_BUSY;
          cnt_next   = md_is_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      MD_BUSY: begin
        if (exc_flush) begin
          state_next = IDLE;
          cnt_next   = 6'd0;
        end else if (cnt > 6'd1) begin
          cnt_next = cnt - 6'd1;
        end else if (cnt == 6'd1 && stall_req_mem) begin
          cnt_next = cnt;
        end else begin
          state_next = IDLE;
          cnt_next   = 6'd0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 6'd0;
      end
    endcase
  end

  // Reset and exception flush both override every stall request in the same cycle.
  always_comb begin
    stall    = STALL_NONE;
    flush    = 1'b0;
    flush_pc = 32'd0;
    md_busy  = 1'b0;
    md_done  = 1'b0;
    if (!rst) begin
      md_busy = (state == MD_BUSY);
      md_done = last_cycle && !stall_req_mem && !exc_flush;
      if (exc_flush) begin
        flush    = 1'b1;
        flush_pc = exc_pc;
      end else if (stall_req_mem) begin
        stall = STALL_MEM;
      end else if (ex_req) begin
        stall = STALL_EX;
      end else if (stall_req_id) begin
        stall = STALL_ID;
      end else if (stall_req_if) begin
        stall = STALL_IF;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed vectors push hand-computed expectations,
// and a negedge monitor pops and compares them against the DUT outputs.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_req_if;
  logic        stall_req_id;
  logic        stall_req_mem;
  logic        md_start;
  logic        md_is_div;
  logic        exc_flush;
  logic [31:0] exc_pc;
  logic [4:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        md_busy;
  logic        md_done;

  typedef struct {
    string       name;
    logic [4:0]  stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] EPC = 32'hBFC00380;

  pipeline_ctrl #(.MUL_CYCLES(3), .DIV_CYCLES(32)) dut (
    .clk(clk),
    .rst(rst),
    .stall_req_if(stall_req_if),
    .stall_req_id(stall_req_id),
    .stall_req_mem(stall_req_mem),
    .md_start(md_start),
    .md_is_div(md_is_div),
    .exc_flush(exc_flush),
    .exc_pc(exc_pc),
    .stall(stall),
    .flush(flush),
    .flush_pc(flush_pc),
    .md_busy(md_busy),
    .md_done(md_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input exp_t e);
    checks += 5;
    if (stall !== e.stall) begin
      errors++;
      $display("[TB] FAIL %s stall got %b want %b", e.name, stall, e.stall);
    end
    if (flush !== e.flush) begin
      errors++;
      $display("[TB] FAIL %s flush got %b want %b", e.name, flush, e.flush);
    end
    if (flush_pc !== e.flush_pc) begin
      errors++;
      $display("[TB] FAIL %s flush_pc got %h want %h", e.name, flush_pc, e.flush_pc);
    end
    if (md_busy !== e.busy) begin
      errors++;
      $display("[TB] FAIL %s md_busy got %b want %b", e.name, md_busy, e.busy);
    end
    if (md_done !== e.done) begin
      errors++;
      $display("[TB] FAIL %s md_done got %b want %b", e.name, md_done, e.done);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  // Drive one cycle of inputs, queue its expected response, then advance past the edge.
  task automatic applyStimulus(input string name,
                               input logic r, input logic sif, input logic sid, input logic smem,
                               input logic st, input logic dv, input logic exf, input logic [31:0] epc,
                               input logic [4:0] e_stall, input logic e_flush, input logic [31:0] e_pc,
                               input logic e_busy, input logic e_done);
    exp_t e;
    rst = r; stall_req_if = sif; stall_req_id = sid; stall_req_mem = smem;
    md_start = st; md_is_div = dv; exc_flush = exf; exc_pc = epc;
    e.name = name; e.stall = e_stall; e.flush = e_flush; e.flush_pc = e_pc;
    e.busy = e_busy; e.done = e_done;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle(input string name, input logic e_busy);
    applyStimulus(name, 0,0,0,0, 0,0,0,32'd0, 5'b00000,0,32'd0, e_busy,0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired queue=%0d want 0", exp_q.size());
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1; stall_req_if = 0; stall_req_id = 0; stall_req_mem = 0;
    md_start = 0; md_is_div = 0; exc_flush = 0; exc_pc = 32'd0;
    @(posedge clk);
    #1;

    applyStimulus("reset_noisy", 1, 1,1,1, 1,1,1,EPC, 5'b00000,0,32'd0, 0,0);
    idleCycle("post_reset_idle", 0);

    applyStimulus("prio_if_id",     0, 1,1,0, 0,0,0,32'd0, 5'b00011,0,32'd0, 0,0);
    applyStimulus("prio_if_id_mem", 0, 1,1,1, 0,0,0,32'd0, 5'b01111,0,32'd0, 0,0);
    applyStimulus("prio_if_only",   0, 1,0,0, 0,0,0,32'd0, 5'b00001,0,32'd0, 0,0);
    applyStimulus("flush_override", 0, 1,0,1, 0,0,1,32'h12345678, 5'b00000,1,32'h12345678, 0,0);

    applyStimulus("mul_t0",         0, 0,0,0, 1,0,0,32'd0, 5'b00111,0,32'd0, 0,0);
    applyStimulus("mul_t1_restart", 0, 0,0,0, 1,1,0,32'd0, 5'b00111,0,32'd0, 1,0);
    applyStimulus("mul_t2_id",      0, 0,1,0, 0,0,0,32'd0, 5'b00111,0,32'd0, 1,0);
    applyStimulus("mul_t3_done",    0, 0,1,0, 0,0,0,32'd0, 5'b00011,0,32'd0, 1,1);
    idleCycle("mul_t4_idle", 0);

    applyStimulus("start_with_flush", 0, 0,0,0, 1,1,1,EPC, 5'b00000,1,EPC, 0,0);
    idleCycle("start_flush_after", 0);

    applyStimulus("div_t0", 0, 0,0,0, 1,1,0,32'd0, 5'b00111,0,32'd0, 0,0);
    for (int i = 1; i <= 30; i++)
      applyStimulus("div_count", 0, 0,0,0, 0,0,0,32'd0, 5'b00111,0,32'd0, 1,0);
    for (int i = 31; i <= 33; i++)
      applyStimulus("div_mem_hold", 0, 0,0,1, 0,0,0,32'd0, 5'b01111,0,32'd0, 1,0);
    applyStimulus("div_t34_done", 0, 0,0,0, 0,0,0,32'd0, 5'b00000,0,32'd0, 1,1);
    idleCycle("div_t35_idle", 0);

    applyStimulus("abort_t0", 0, 0,0,0, 1,1,0,32'd0, 5'b00111,0,32'd0, 0,0);
    for (int i = 1; i <= 9; i++)
      applyStimulus("abort_count", 0, 0,0,0, 0,0,0,32'd0, 5'b00111,0,32'd0, 1,0);
    applyStimulus("abort_t10_flush", 0, 0,0,0, 0,0,1,EPC, 5'b00000,1,EPC, 1,0);
    idleCycle("abort_t11", 0);
    idleCycle("abort_t12", 0);

    applyStimulus("lastflush_t0", 0, 0,0,0, 1,0,0,32'd0, 5'b00111,0,32'd0, 0,0);
    applyStimulus("lastflush_t1", 0, 0,0,0, 0,0,0,32'd0, 5'b00111,0,32'd0, 1,0);
    applyStimulus("lastflush_t2", 0, 0,0,0, 0,0,0,32'd0, 5'b00111,0,32'd0, 1,0);
    applyStimulus("lastflush_t3", 0, 0,0,0, 0,0,1,EPC, 5'b00000,1,EPC, 1,0);
    idleCycle("lastflush_t4", 0);

    applyStimulus("rstmid_t0", 0, 0,0,0, 1,1,0,32'd0, 5'b00111,0,32'd0, 0,0);
    for (int i = 1; i <= 4; i++)
      applyStimulus("rstmid_count", 0, 0,0,0, 0,0,0,32'd0, 5'b00111,0,32'd0, 1,0);
    applyStimulus("rstmid_t5_rst", 1, 0,1,0, 0,0,1,EPC, 5'b00000,0,32'd0, 0,0);
    applyStimulus("rstmid_t6_start", 0, 0,0,0, 1,0,0,32'd0, 5'b00111,0,32'd0, 0,0);
    applyStimulus("rstmid_t7", 0, 0,0,0, 0,0,0,32'd0, 5'b00111,0,32'd0, 1,0);
    applyStimulus("rstmid_t8", 0, 0,0,0, 0,0,0,32'd0, 5'b00111,0,32'd0, 1,0);
    applyStimulus("rstmid_t9_done", 0, 0,0,0, 0,0,0,32'd0, 5'b00000,0,32'd0, 1,1);
    idleCycle("rstmid_t10", 0);

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
